// File: rtl/ibr128_pkg.sv
// Shared types and constants for the IBR128 message sequencer and its core.
package ibr128_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  localparam int unsigned WORDS_PER_BLK = 4;

  typedef enum logic [1:0] {
    SOM_ECB = 2'd0,
    SOM_CBC = 2'd1,
    SOM_CFB = 2'd2,
    SOM_OFB = 2'd3
  } som_t;

endpackage

// File: rtl/ibr128_block_unpacker.sv
// Holds one 128-bit cipher block and serializes it MSW-first as four 32-bit words.
module ibr128_block_unpacker
  import ibr128_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [127:0] blk,
  input  logic         blk_last,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_valid,
  output logic         m_last,
  output logic         done
);

  logic [127:0] hold;
  logic [1:0]   cnt;
  logic         last_q;
  logic         final_word;

  assign final_word = (cnt == 2'(WORDS_PER_BLK - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold    <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      hold    <= blk;
      cnt     <= '0;
      m_valid <= 1'b1;
      last_q  <= blk_last;
    end else if (m_valid && m_ready) begin
      // Shift so the next word is always on the top lane; m_data needs no mux.
      hold <= {hold[95:0], 32'h0};
      cnt  <= cnt + 2'd1;
      if (final_word) m_valid <= 1'b0;
    end
  end

  assign m_data = hold[127:96];
  assign m_last = m_valid && last_q && final_word;
  assign done   = m_valid && m_ready && final_word;

endmodule

// File: rtl/ibr128_msg_sequencer.sv
// Packs a 32-bit word stream into 128-bit blocks, runs each through IBR128_core, and streams results back out.
module ibr128_msg_sequencer
  import ibr128_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_last,
  input  logic         cfg_encrypt,
  input  logic         cfg_sa,
  input  logic [1:0]   cfg_som,
  input  logic [127:0] cfg_iv,
  input  logic [63:0]  cfg_key0,
  input  logic [63:0]  cfg_key1,
  output logic         core_enable,
  output logic [127:0] core_plaintext,
  output logic         core_fb,
  output logic         core_encrypt,
  output logic         core_sa,
  output logic [1:0]   core_som,
  output logic [127:0] core_iv,
  output logic [63:0]  core_key0,
  output logic [63:0]  core_key1,
  input  logic [127:0] core_cipher,
  input  logic         core_ready,
  output logic [31:0]  m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         err_timeout
);

  seq_state_t   state_q, state_d;
  logic         live;
  logic [1:0]   idx;
  logic         fb_flag;
  logic         last_blk;
  logic [31:0]  run_cnt;
  logic [127:0] plaintext;
  logic [127:0] blk_d;
  logic         accept, capture, tmo, drain_done, unpack_done;

  assign s_ready        = live && (state_q == IDLE || state_q == LOAD);
  assign core_enable    = (state_q == RUN);
  assign core_fb        = fb_flag;
  assign core_plaintext = plaintext;
  assign accept         = s_ready && s_valid;

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    tmo        = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      // A one-word message goes straight to RUN instead of stalling in LOAD.
      IDLE:  if (accept) state_d = s_last ? RUN : LOAD;
      LOAD:  if (accept && (s_last || idx == 2'(WORDS_PER_BLK - 1))) state_d = RUN;
      RUN: begin
        // First RUN cycle ignores core_ready: it may still be high from the last block.
        if (run_cnt != '0 && core_ready) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else if (run_cnt == 32'(TIMEOUT_CYC - 1)) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        drain_done = unpack_done;
        if (unpack_done) state_d = last_blk ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blk_d = (state_q == IDLE) ? '0 : plaintext;
    case (idx)
      2'd0:    blk_d[127:96] = s_data;
      2'd1:    blk_d[95:64]  = s_data;
      2'd2:    blk_d[63:32]  = s_data;
      default: blk_d[31:0]   = s_data;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      live         <= 1'b0;
      idx          <= '0;
      fb_flag      <= 1'b0;
      last_blk     <= 1'b0;
      run_cnt      <= '0;
      plaintext    <= '0;
      err_timeout  <= 1'b0;
      core_encrypt <= 1'b0;
      core_sa      <= 1'b0;
      core_som     <= '0;
      core_iv      <= '0;
      core_key0    <= '0;
      core_key1    <= '0;
    end else begin
      live <= 1'b1;
      if (state_q == RUN) run_cnt <= run_cnt + 32'd1;
      if (accept) begin
        plaintext <= blk_d;
        idx       <= idx + 2'd1;
        if (state_q == IDLE) begin
          fb_flag      <= 1'b1;
          core_encrypt <= cfg_encrypt;
          core_sa      <= cfg_sa;
          core_som     <= cfg_som;
          core_iv      <= cfg_iv;
          core_key0    <= cfg_key0;
          core_key1    <= cfg_key1;
        end
        if (state_d == RUN) begin
          idx      <= '0;
          last_blk <= s_last;
          run_cnt  <= '0;
        end
      end
      if (capture) fb_flag <= 1'b0;
      if (tmo) begin
        err_timeout <= 1'b1;
        fb_flag     <= 1'b0;
        last_blk    <= 1'b0;
        plaintext   <= '0;
      end
      // Clearing here gives zero padding for a short final block.
      if (drain_done && !last_blk) plaintext <= '0;
    end
  end

  ibr128_block_unpacker u_unpacker (
    .clk      (Clk),
    .rst      (Rst),
    .load     (capture),
    .blk      (core_cipher),
    .blk_last (last_blk),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .done     (unpack_done)
  );

endmodule

// File: tb/tb_ibr128_msg_sequencer.sv
// Directed bench for ibr128_msg_sequencer with a stub core and expected-block/word scoreboards.
module tb_ibr128_msg_sequencer;

  localparam int unsigned LAT = 5;
  localparam logic [127:0] CIPH_BASE = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [31:0]  s_data;
  logic         s_valid, s_ready, s_last;
  logic         cfg_encrypt, cfg_sa;
  logic [1:0]   cfg_som;
  logic [127:0] cfg_iv;
  logic [63:0]  cfg_key0, cfg_key1;
  logic         core_enable, core_fb, core_encrypt, core_sa;
  logic [127:0] core_plaintext, core_iv, core_cipher;
  logic [1:0]   core_som;
  logic [63:0]  core_key0, core_key1;
  logic         core_ready;
  logic [31:0]  m_data;
  logic         m_valid, m_ready, m_last, err_timeout;

  typedef struct packed {
    logic [127:0] pt;
    logic         fb;
    logic         last;
  } blk_t;

  blk_t        q_blk[$];
  logic [32:0] q_out[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          stub_mode = 0;  // 0 normal, 1 never ready, 2 manual
  int unsigned en_cnt = 0;
  logic [31:0] blk_seq = '0;
  logic        cur_last = 1'b0;

  ibr128_msg_sequencer #(.TIMEOUT_CYC(16)) dut (
    .Clk(Clk), .Rst(Rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .cfg_encrypt(cfg_encrypt), .cfg_sa(cfg_sa), .cfg_som(cfg_som), .cfg_iv(cfg_iv),
    .cfg_key0(cfg_key0), .cfg_key1(cfg_key1),
    .core_enable(core_enable), .core_plaintext(core_plaintext), .core_fb(core_fb),
    .core_encrypt(core_encrypt), .core_sa(core_sa), .core_som(core_som), .core_iv(core_iv),
    .core_key0(core_key0), .core_key1(core_key1),
    .core_cipher(core_cipher), .core_ready(core_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .err_timeout(err_timeout)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stub core: ready is held over into the next block's first RUN cycle on purpose.
  always @(posedge Clk) begin
    #1;
    if (stub_mode != 2) begin
      if (core_enable) begin
        en_cnt++;
        if (en_cnt == 1) begin
          check("blk_expected", 128'(q_blk.size() != 0), 128'd1);
          if (q_blk.size() != 0) begin
            blk_t e;
            e = q_blk.pop_front();
            check("core_plaintext", core_plaintext, e.pt);
            check("core_fb", 128'(core_fb), 128'(e.fb));
            cur_last = e.last;
          end
        end
        if (en_cnt == 2) core_ready = 1'b0;
        if (stub_mode == 0 && en_cnt == LAT) begin
          core_cipher = CIPH_BASE ^ {4{blk_seq}};
          blk_seq++;
          core_ready = 1'b1;
          for (int i = 0; i < 4; i++)
            q_out.push_back({cur_last && (i == 3), core_cipher[(3 - i) * 32 +: 32]});
        end
      end else begin
        en_cnt = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (m_valid && m_ready) begin
      check("out_expected", 128'(q_out.size() != 0), 128'd1);
      if (q_out.size() != 0) check("m_last_data", 128'({m_last, m_data}), 128'(q_out.pop_front()));
    end
  end

  task automatic send_word(input logic [31:0] d, input logic l);
    int unsigned n = 0;
    s_data = d; s_last = l; s_valid = 1'b1;
    @(negedge Clk);
    while (!s_ready && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("s_ready_wait", 128'(s_ready), 128'd1);
    @(posedge Clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic expect_msg(input logic [31:0] w [8], input int n);
    for (int b = 0; b * 4 < n; b++) begin
      blk_t e;
      e.pt = '0;
      for (int i = 0; i < 4; i++)
        if (b * 4 + i < n) e.pt[(3 - i) * 32 +: 32] = w[b * 4 + i];
      e.fb   = (b == 0);
      e.last = ((b + 1) * 4 >= n);
      q_blk.push_back(e);
    end
  endtask

  task automatic wait_quiet(input string tag);
    int unsigned n = 0;
    bit ok = 1'b0;
    while (n < 400 && !ok) begin
      @(negedge Clk);
      n++;
      if (q_blk.size() == 0 && q_out.size() == 0 && s_ready && !core_enable && !m_valid) ok = 1'b1;
    end
    check(tag, 128'(ok), 128'd1);
    @(posedge Clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 128'(s_ready), 128'd0);
    check({tag, "_enable"}, 128'(core_enable), 128'd0);
    check({tag, "_m_valid"}, 128'(m_valid), 128'd0);
    check({tag, "_m_last"}, 128'(m_last), 128'd0);
    check({tag, "_err"}, 128'(err_timeout), 128'd0);
    check({tag, "_pt"}, core_plaintext, 128'd0);
    check({tag, "_fb"}, 128'(core_fb), 128'd0);
    check({tag, "_iv"}, core_iv, 128'd0);
    check({tag, "_key0"}, 128'(core_key0), 128'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w [8];
    logic [31:0] d0;
    int unsigned n;

    Rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    cfg_encrypt = 1'b0; cfg_sa = 1'b0; cfg_som = '0; cfg_iv = '0; cfg_key0 = '0; cfg_key1 = '0;
    core_ready = 1'b0; core_cipher = '0;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_reset_outputs("rst");
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("s_ready_after_rst", 128'(s_ready), 128'd1);

    // Single 4-word message
    cfg_encrypt = 1'b1; cfg_sa = 1'b1; cfg_som = 2'd2;
    cfg_iv = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    cfg_key0 = 64'h1111_2222_3333_4444; cfg_key1 = 64'h5555_6666_7777_8888;
    w = '{32'h123456ab, 32'hcd132536, 32'h123456ab, 32'hcd132536, 0, 0, 0, 0};
    expect_msg(w, 4);
    for (int k = 0; k < 4; k++) send_word(w[k], k == 3);
    check("enable_after_4th", 128'(core_enable), 128'd1);
    check("s_ready_in_run", 128'(s_ready), 128'd0);
    wait_quiet("msg4_done");
    check("core_iv", core_iv, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    check("core_key1", 128'(core_key1), 128'h5555_6666_7777_8888);
    check("core_mode", 128'({core_encrypt, core_sa, core_som}), 128'b1110);

    // 8-word message, cfg changed after the first word
    cfg_iv = 128'h2;
    w = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404,
          32'h05050505, 32'h06060606, 32'h07070707, 32'h08080808};
    expect_msg(w, 8);
    for (int k = 0; k < 8; k++) begin
      send_word(w[k], k == 7);
      if (k == 0) begin cfg_iv = 128'h3; cfg_som = 2'd1; end
    end
    wait_quiet("msg8_done");
    check("iv_held_midmsg", core_iv, 128'h2);
    check("som_held_midmsg", 128'(core_som), 128'd2);

    // Early s_last: zero padding
    w = '{32'h11111111, 32'h22222222, 0, 0, 0, 0, 0, 0};
    expect_msg(w, 2);
    send_word(w[0], 1'b0);
    send_word(w[1], 1'b1);
    wait_quiet("msg2_done");

    // Output backpressure
    m_ready = 1'b0;
    w = '{32'hdeadbeef, 32'hcafef00d, 32'h0badc0de, 32'h8badf00d, 0, 0, 0, 0};
    expect_msg(w, 4);
    for (int k = 0; k < 4; k++) send_word(w[k], k == 3);
    n = 0;
    while (!m_valid && n < 100) begin @(negedge Clk); n++; end
    check("bp_m_valid_seen", 128'(m_valid), 128'd1);
    d0 = m_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      check("bp_m_valid", 128'(m_valid), 128'd1);
      check("bp_m_data", 128'(m_data), 128'(d0));
      check("bp_s_ready", 128'(s_ready), 128'd0);
      check("bp_enable", 128'(core_enable), 128'd0);
    end
    @(posedge Clk); #1;
    m_ready = 1'b1;
    wait_quiet("bp_done");

    // Timeout: core never answers
    stub_mode = 1;
    w = '{32'h0a0a0a0a, 32'h0b0b0b0b, 32'h0c0c0c0c, 32'h0d0d0d0d, 0, 0, 0, 0};
    expect_msg(w, 4);
    for (int k = 0; k < 4; k++) send_word(w[k], k == 3);
    n = 0;
    @(negedge Clk);
    while (core_enable && n < 100) begin n++; @(negedge Clk); end
    check("tmo_run_cycles", 128'(n), 128'd16);
    check("tmo_err", 128'(err_timeout), 128'd1);
    check("tmo_idle", 128'(s_ready), 128'd1);
    check("tmo_no_output", 128'(m_valid), 128'd0);
    @(posedge Clk); #1;
    stub_mode = 0;
    w = '{32'h77777777, 0, 0, 0, 0, 0, 0, 0};
    expect_msg(w, 1);
    send_word(w[0], 1'b1);
    wait_quiet("after_tmo_done");
    check("err_sticky", 128'(err_timeout), 128'd1);

    // Reset in RUN with a stale ready
    stub_mode = 2;
    core_ready = 1'b1;
    w = '{32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666, 0, 0, 0, 0};
    for (int k = 0; k < 4; k++) send_word(w[k], k == 3);
    check("rst_in_run_enable", 128'(core_enable), 128'd1);
    Rst = 1'b1;
    @(posedge Clk); #1;
    check_reset_outputs("midrst");
    Rst = 1'b0;
    @(posedge Clk); #1;
    check("s_ready_after_midrst", 128'(s_ready), 128'd1);
    en_cnt = 0;
    stub_mode = 0;
    w = '{32'h31415926, 32'h53589793, 32'h23846264, 32'h33832795, 0, 0, 0, 0};
    expect_msg(w, 4);
    for (int k = 0; k < 4; k++) send_word(w[k], k == 3);
    wait_quiet("after_midrst_done");

    check("blk_queue_empty", 128'(q_blk.size()), 128'd0);
    check("out_queue_empty", 128'(q_out.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
